// File: rtl/id_ex_if.sv
// id_ex_if: decode-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_if #(parameter int DATA_W = 32, parameter int REG_W = 5, parameter int CNT_W = 16);
  logic id_valid;
  logic [1:0] id_ALUop;
  logic id_RegWrite, id_MemRead, id_MemWrite, id_Mem2Reg, id_isjump, id_usesRt;
  logic [DATA_W-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [REG_W-1:0] id_rs, id_rt, id_wreg;
  logic flush, hold, stall;
  logic ex_valid;
  logic [1:0] ex_ALUop;
  logic ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Mem2Reg, ex_isjump;
  logic [DATA_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_wreg;
  logic [CNT_W-1:0] bubble_count;
  modport master (
    output id_valid, id_ALUop, id_RegWrite, id_MemRead, id_MemWrite, id_Mem2Reg, id_isjump, id_usesRt,
    output id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_wreg, flush, hold,
    input stall, ex_valid, ex_ALUop, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Mem2Reg, ex_isjump,
    input ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_wreg, bubble_count
  );
  modport slave (
    input id_valid, id_ALUop, id_RegWrite, id_MemRead, id_MemWrite, id_Mem2Reg, id_isjump, id_usesRt,
    input id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_wreg, flush, hold,
    output stall, ex_valid, ex_ALUop, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Mem2Reg, ex_isjump,
    output ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_wreg, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion and saturating bubble counter
module id_ex_stage #(parameter int DATA_W = 32, parameter int REG_W = 5, parameter int CNT_W = 16) (
  input logic clk,
  input logic reset,
  id_ex_if.slave p
);
  typedef struct packed {
    logic valid;
    logic [1:0] alu_op;
    logic reg_write, mem_read, mem_write, mem2reg, isjump;
    logic [DATA_W-1:0] pc, rd1, rd2, imm;
    logic [REG_W-1:0] rs, rt, wreg;
  } ex_t;
  function automatic ex_t kill(input ex_t e);
    kill = e;
    kill.valid = 1'b0;
    kill.alu_op = 2'b0;
    kill.reg_write = 1'b0;
    kill.mem_read = 1'b0;
    kill.mem_write = 1'b0;
    kill.mem2reg = 1'b0;
    kill.isjump = 1'b0;
  endfunction
  ex_t ex_q, ex_d, id_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_use;
  always_comb begin
    id_w = '{valid: p.id_valid, alu_op: p.id_ALUop, reg_write: p.id_RegWrite, mem_read: p.id_MemRead,
             mem_write: p.id_MemWrite, mem2reg: p.id_Mem2Reg, isjump: p.id_isjump, pc: p.id_pc,
             rd1: p.id_rd1, rd2: p.id_rd2, imm: p.id_imm, rs: p.id_rs, rt: p.id_rt, wreg: p.id_wreg};
    load_use = p.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.wreg != '0) &
               ((ex_q.wreg == p.id_rs) | (p.id_usesRt & (ex_q.wreg == p.id_rt)));
    ex_d = (p.flush | (~p.hold & load_use)) ? kill(ex_q) : p.hold ? ex_q : p.id_valid ? id_w : kill(id_w);
    cnt_d = (~p.flush & ~p.hold & load_use & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      cnt_q <= cnt_d;
    end
  end
  assign p.stall = load_use & ~p.flush & ~reset;
  assign p.ex_valid = ex_q.valid;
  assign p.ex_ALUop = ex_q.alu_op;
  assign p.ex_RegWrite = ex_q.reg_write;
  assign p.ex_MemRead = ex_q.mem_read;
  assign p.ex_MemWrite = ex_q.mem_write;
  assign p.ex_Mem2Reg = ex_q.mem2reg;
  assign p.ex_isjump = ex_q.isjump;
  assign p.ex_pc = ex_q.pc;
  assign p.ex_rd1 = ex_q.rd1;
  assign p.ex_rd2 = ex_q.rd2;
  assign p.ex_imm = ex_q.imm;
  assign p.ex_rs = ex_q.rs;
  assign p.ex_rt = ex_q.rt;
  assign p.ex_wreg = ex_q.wreg;
  assign p.bubble_count = cnt_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the control word and operands produced by the decode stage.
- Captures ALUop (2 bits, isRtype/isbranch encoded) together with the other control bits, register data, immediate and register numbers, and presents them to the EX stage one cycle later.
- Contains load-use hazard detection. It asserts a stall to the PC and IF/ID register and inserts a bubble into EX.
- Keeps a saturating count of bubble cycles for performance analysis.

Parameters:
DATA_W, 32, width of PC, register-data and immediate fields
REG_W, 5, width of register-number fields
CNT_W, 16, width of the bubble counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_ALUop  input  2  ALUop from control unit ([1]=isRtype, [0]=isbranch)
id_RegWrite  input  1  instruction writes register file
id_MemRead  input  1  load
id_MemWrite  input  1  store
id_Mem2Reg  input  1  writeback selects memory data
id_isjump  input  1  jump instruction
id_usesRt  input  1  instruction reads rt as a source
id_pc  input  DATA_W  PC+4 of ID instruction
id_rd1  input  DATA_W  register read data 1
id_rd2  input  DATA_W  register read data 2
id_imm  input  DATA_W  sign-extended immediate
id_rs  input  REG_W  source register rs
id_rt  input  REG_W  source register rt
id_wreg  input  REG_W  destination register (already muxed rd/rt)
flush  input  1  branch/jump taken in EX, kill ID instruction
hold  input  1  global freeze (e.g. memory not ready)
stall  output  1  freeze PC and IF/ID this cycle (combinational)
ex_valid  output  1  EX holds a real instruction
ex_ALUop  output  2  registered ALUop
ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Mem2Reg, ex_isjump  output  1 each  registered control
ex_pc, ex_rd1, ex_rd2, ex_imm  output  DATA_W  registered data
ex_rs, ex_rt, ex_wreg  output  REG_W  registered register numbers
bubble_count  output  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset:
  - On a clk edge with reset=1, all ex_* outputs and bubble_count clear to 0.
  - stall=0 while reset=1.
- Hazard detection (combinational):
  - load_use = id_valid & ex_valid & ex_MemRead & (ex_wreg!=0) & ((ex_wreg==id_rs) | (id_usesRt & ex_wreg==id_rt)).
  - stall = load_use & ~flush & ~reset.
- Register update on each rising edge, priority highest first:
  1. reset: clear everything.
  2. flush: bubble. ex_valid=0, and ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Mem2Reg, ex_isjump and ex_ALUop all 0. Data fields are don't-care and are implemented as held. The counter is not incremented.
  3. hold: all ex_* registers and the counter keep their values.
  4. load_use: bubble, same as flush. bubble_count increments by 1.
  5. otherwise: load all id_* fields. ex_valid=id_valid. If id_valid=0, all control bits load as 0 regardless of inputs.
- Latency: exactly one cycle from ID to EX outputs. stall has zero latency.
- Bubble duration: a load-use bubble lasts one cycle. The following cycle, ex_MemRead=0 and stall deasserts, so the held ID instruction advances.
- Saturation: bubble_count stops at 2^CNT_W-1 and never wraps.
- Simultaneous events:
  - flush and load_use together: flush wins and stall=0, because the ID instruction is killed.
  - hold and load_use together: the registers freeze. stall is still asserted, which is harmless because upstream is also held.
- Register zero: ex_wreg==0 never creates a hazard.
- No other state: the block has no internal FSM beyond the pipeline register and the counter.

Test Plan:
1. Reset: assert reset 2 cycles with all id_* inputs at nonzero values -> all ex_* outputs=0, bubble_count=0, stall=0.
2. Normal R-type pass-through: id_valid=1, id_ALUop=2'b10, id_RegWrite=1, id_rd1=0x11, id_rd2=0x22, id_wreg=3 -> on the next edge ex_ALUop=2'b10, ex_rd1=0x11, ex_rd2=0x22, ex_wreg=3, ex_valid=1, stall=0.
3. Load-use on rs: EX holds lw with ex_wreg=5 and ex_MemRead=1; ID presents an instruction with id_rs=5 -> stall=1 the same cycle. Next edge: ex_valid=0, ex_RegWrite=0, bubble_count=1. Following edge: the ID instruction loads and stall=0.
4. Load-use on rt gated by id_usesRt, plus register zero:
   - ex_wreg=7, id_rt=7, id_usesRt=0 -> stall=0.
   - ex_wreg=0 with id_rs=0 -> stall=0.
5. Flush priority: the load-use condition is present and flush=1 -> stall=0, next edge ex_valid=0, bubble_count unchanged.
6. Hold and saturation:
   - With hold=1 for 3 cycles while id_* inputs change -> ex_* outputs unchanged.
   - Preload CNT_W=2 and force 5 load-use bubbles -> bubble_count stops at 3.
